// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces one raw button, emitting press/release/auto-repeat pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic event_pulse
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY == 0 ? 0 : REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state, state_n;
  logic sync1, sync2, btn;
  logic [DW-1:0] cnt, cnt_n;
  logic [RW-1:0] rpt_cnt, rpt_n;
  logic first, first_n, press_n, release_n, repeat_n, level_n;
  assign btn = sync2 ^ ACTIVE_LOW;
  assign event_pulse = press | repeat_pulse;
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync1, sync2} <= {2{ACTIVE_LOW}};
    else {sync1, sync2} <= {btn_raw, sync1};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rpt_cnt       <= '0;
      first         <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rpt_cnt       <= rpt_n;
      first         <= first_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
    end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rpt_n     = rpt_cnt;
    first_n   = first;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE:
        if (btn) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      PRESS_WAIT:
        if (!btn) state_n = IDLE;
        else if (cnt == D_LAST) begin
          state_n = HELD;
          press_n = 1'b1;
          rpt_n   = '0;
          first_n = 1'b1;
        end else cnt_n = cnt + DW'(1);
      HELD:
        if (!btn) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rpt_cnt == (first ? RD_LAST : RP_LAST)) begin
            repeat_n = 1'b1;
            rpt_n    = '0;
            first_n  = 1'b0;
          end else rpt_n = rpt_cnt + RW'(1);
        end
      RELEASE_WAIT:
        if (btn) state_n = HELD;
        else if (cnt == D_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else cnt_n = cnt + DW'(1);
      default: state_n = IDLE;
    endcase
    level_n = (state_n == HELD) || (state_n == RELEASE_WAIT);
  end
endmodule
